branch_pht: RTL

- PC-indexed pattern history table of 2^IDX_W saturating counters, each CNT_W bits wide.
- Generalises the single 2-bit predictor to a table with registered lookup, a same-cycle update bypass and an optional gshare history hash.
- Sits beside the fetch PC: IF issues the lookup, EX issues the update on branch resolution.

---
 rtl/branch_pht_if.sv | 30 +++
 rtl/branch_pht.sv | 97 +++++++++
 2 files changed

// File: rtl/branch_pht_if.sv
// Lookup / prediction / update bundle for the pattern history table.
// Master sits on the fetch/execute side, slave is the table itself.
interface branch_pht_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 2,
   parameter int GHR_W = 6
);
   logic             lk_valid;
   logic [PC_W-1:0]  lk_pc;
   logic             pred_valid;
   logic             pred_taken;
   logic [CNT_W-1:0] pred_cnt;
   logic [GHR_W-1:0] pred_ghr;
   logic             upd_valid;
   logic [PC_W-1:0]  upd_pc;
   logic             upd_taken;
   logic [GHR_W-1:0] upd_ghr;

   modport master (
      output lk_valid, lk_pc,
      output upd_valid, upd_pc, upd_taken, upd_ghr,
      input  pred_valid, pred_taken, pred_cnt, pred_ghr
   );

   modport slave (
      input  lk_valid, lk_pc,
      input  upd_valid, upd_pc, upd_taken, upd_ghr,
      output pred_valid, pred_taken, pred_cnt, pred_ghr
   );
endinterface

// File: rtl/branch_pht.sv
// PC-indexed table of saturating counters, 1-cycle lookup, write-first bypass.
// Define BRANCH_PHT_GSHARE_EN to hash indices with a global history register.
module branch_pht #(
   parameter int PC_W    = 32,
   parameter int IDX_W   = 6,
   parameter int CNT_W   = 2,
   parameter int RST_CNT = 0,
   parameter int GHR_W   = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   branch_pht_if.slave  bus
);
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] CRST = CNT_W'(RST_CNT);

   logic [CNT_W-1:0] ctr [DEPTH];
   logic [IDX_W-1:0] li;
   logic [IDX_W-1:0] ui;
   logic [CNT_W-1:0] upd_cur;
   logic [CNT_W-1:0] upd_nxt;
   logic [CNT_W-1:0] lk_cnt;
   logic             unused_bits;

`ifdef BRANCH_PHT_GSHARE_EN
   logic [GHR_W-1:0] ghr;
   logic [GHR_W:0]   ghr_shift;

   assign li = bus.lk_pc[IDX_W+1:2] ^ IDX_W'(ghr);
   assign ui = bus.upd_pc[IDX_W+1:2] ^ IDX_W'(bus.upd_ghr);
   assign ghr_shift = {ghr, bus.upd_taken};

   // History is committed at resolve time only, never speculatively.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (bus.upd_valid) begin
         ghr <= ghr_shift[GHR_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pred_ghr <= '0;
      end else if (bus.lk_valid) begin
         bus.pred_ghr <= ghr;
      end
   end

   assign unused_bits = ^{bus.lk_pc, bus.upd_pc, ghr_shift[GHR_W]};
`else
   assign li = bus.lk_pc[IDX_W+1:2];
   assign ui = bus.upd_pc[IDX_W+1:2];
   assign bus.pred_ghr = '0;
   assign unused_bits = ^{bus.lk_pc, bus.upd_pc, bus.upd_ghr};
`endif

   assign upd_cur = ctr[ui];

   always_comb begin
      upd_nxt = upd_cur;
      if (bus.upd_taken) begin
         if (upd_cur != CMAX) upd_nxt = upd_cur + 1'b1;
      end else begin
         if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
      end
   end

   // Same-index update wins so the prediction sees the post-update count.
   always_comb begin
      lk_cnt = ctr[li];
      if (bus.upd_valid && (ui == li)) lk_cnt = upd_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ctr[i] <= CRST;
      end else if (bus.upd_valid) begin
         ctr[ui] <= upd_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pred_valid <= 1'b0;
         bus.pred_taken <= 1'b0;
         bus.pred_cnt   <= '0;
      end else begin
         bus.pred_valid <= bus.lk_valid;
         if (bus.lk_valid) begin
            bus.pred_cnt   <= lk_cnt;
            bus.pred_taken <= lk_cnt[CNT_W-1];
         end
      end
   end
endmodule
